// File: rtl/seq_decoder_nxm_if.sv
// Control/status bundle for the one-hot decoder and its sweep sequencer.
interface seq_decoder_nxm_if #(
  parameter int SEL_W = 3
);
  localparam int OUT_W = 2 ** SEL_W;

  logic             en;
  logic             load;
  logic             start;
  logic [SEL_W-1:0] sel;
  logic [OUT_W-1:0] y;
  logic [SEL_W-1:0] code;
  logic             busy;
  logic             done;

  modport master (
    output en, load, start, sel,
    input  y, code, busy, done
  );

  modport slave (
    input  en, load, start, sel,
    output y, code, busy, done
  );
endinterface

// File: rtl/seq_decoder_nxm.sv
// Registered N-to-2^N one-hot decoder with a built-in code sweep sequencer.
// state | meaning: IDLE = direct load/decode, SWEEP = walking codes, DONE = one-cycle completion pulse
module seq_decoder_nxm #(
  parameter int SEL_W       = 3,
  parameter int HOLD_CYCLES = 10,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_decoder_nxm_if.slave  bus
);
  localparam int OUT_W = 2 ** SEL_W;
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [SEL_W-1:0] CODE_LAST = '1;
  localparam logic [OUT_W-1:0] Y_IDLE    = {OUT_W{ACTIVE_LOW}};
  localparam logic [OUT_W-1:0] ONE       = OUT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [SEL_W-1:0] code_q, code_next;
  logic [CNT_W-1:0] hold_cnt, hold_next;
  logic [OUT_W-1:0] y_q, y_next;
  logic             busy_q, done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      code_q   <= '0;
      hold_cnt <= '0;
      y_q      <= Y_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_next;
      code_q   <= code_next;
      hold_cnt <= hold_next;
      y_q      <= y_next;
      busy_q   <= (state_next == SWEEP);
      done_q   <= (state_next == DONE);
    end
  end

  always_comb begin
    state_next = state;
    code_next  = code_q;
    hold_next  = hold_cnt;
    case (state)
      IDLE: begin
        if (bus.start) begin
          code_next  = '0;
          hold_next  = '0;
          state_next = SWEEP;
        end else if (bus.load) begin
          code_next = bus.sel;
        end
      end
      SWEEP: begin
        // en low freezes both counters so the sweep resumes exactly where it paused
        if (bus.en) begin
          if (hold_cnt == HOLD_LAST) begin
            hold_next = '0;
            if (code_q == CODE_LAST) state_next = DONE;
            else                     code_next  = code_q + 1'b1;
          end else begin
            hold_next = hold_cnt + 1'b1;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    y_next = (bus.en ? (ONE << code_next) : '0) ^ Y_IDLE;
  end

  assign bus.y    = y_q;
  assign bus.code = code_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_seq_decoder_nxm.sv
// Directed bench: table-driven direct decode plus hand-written sweep/pause/priority sequences.
module tb_seq_decoder_nxm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  seq_decoder_nxm_if #(.SEL_W(3)) ia ();
  seq_decoder_nxm_if #(.SEL_W(3)) ib ();

  seq_decoder_nxm #(.SEL_W(3), .HOLD_CYCLES(4), .ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia)
  );
  seq_decoder_nxm #(.SEL_W(3), .HOLD_CYCLES(1), .ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib)
  );

  typedef struct {
    logic       en;
    logic       load;
    logic [2:0] sel;
    logic [7:0] exp_y;
    logic [2:0] exp_code;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Runs a sweep on dut_a; en is dropped for p_len edges starting at edge p_from.
  task automatic sweep_a(input int p_from, input int p_len, input int limit,
                         output int done_at, output int errs);
    int         eff;
    int         k;
    logic       ene;
    logic [7:0] ey;
    done_at = -1;
    errs    = 0;
    eff     = 0;
    ia.en    = 1'b1;
    ia.start = 1'b1;
    tick();
    ia.start = 1'b0;
    check("sweep_start_busy", ia.busy, 1);
    check("sweep_start_y", ia.y, 8'h01);
    for (int n = 1; n <= limit && done_at < 0; n++) begin
      ene   = !(n >= p_from && n < p_from + p_len);
      ia.en = ene;
      tick();
      if (ene) eff++;
      k  = (eff / 4 > 7) ? 7 : eff / 4;
      ey = ene ? (8'h01 << k) : 8'h00;
      if (ia.y !== ey) errs++;
      if (ia.code !== 3'(k)) errs++;
      if (ia.done) done_at = n;
      else if (ia.busy !== 1'b1) errs++;
    end
    ia.en = 1'b1;
  endtask

  task automatic wait_done_a(input string name, input int limit);
    int seen;
    seen = 0;
    for (int n = 0; n < limit && seen == 0; n++) begin
      tick();
      if (ia.done) seen = 1;
    end
    check(name, seen, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int done_at;
    int errs;

    vecs[0]  = '{1'b1, 1'b1, 3'd0, 8'h01, 3'd0};
    vecs[1]  = '{1'b1, 1'b1, 3'd1, 8'h02, 3'd1};
    vecs[2]  = '{1'b1, 1'b1, 3'd2, 8'h04, 3'd2};
    vecs[3]  = '{1'b1, 1'b1, 3'd3, 8'h08, 3'd3};
    vecs[4]  = '{1'b1, 1'b1, 3'd4, 8'h10, 3'd4};
    vecs[5]  = '{1'b1, 1'b1, 3'd5, 8'h20, 3'd5};
    vecs[6]  = '{1'b1, 1'b1, 3'd6, 8'h40, 3'd6};
    vecs[7]  = '{1'b1, 1'b1, 3'd7, 8'h80, 3'd7};
    vecs[8]  = '{1'b0, 1'b1, 3'd3, 8'h00, 3'd3};
    vecs[9]  = '{1'b1, 1'b0, 3'd0, 8'h08, 3'd3};
    vecs[10] = '{1'b0, 1'b0, 3'd6, 8'h00, 3'd3};

    ia.en = 1'b0; ia.load = 1'b0; ia.start = 1'b0; ia.sel = '0;
    ib.en = 1'b0; ib.load = 1'b0; ib.start = 1'b0; ib.sel = '0;
    tick();
    tick();
    check("rst_y", ia.y, 8'h00);
    check("rst_code", ia.code, 0);
    check("rst_busy", ia.busy, 0);
    check("rst_done", ia.done, 0);
    check("rst_b_y", ib.y, 8'hFF);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      ia.en   = vecs[i].en;
      ia.load = vecs[i].load;
      ia.sel  = vecs[i].sel;
      tick();
      check($sformatf("vec%0d_y", i), ia.y, vecs[i].exp_y);
      check($sformatf("vec%0d_code", i), ia.code, vecs[i].exp_code);
      check($sformatf("vec%0d_busy", i), ia.busy, 0);
    end

    // asynchronous reset in the middle of a cycle
    ia.en = 1'b1; ia.load = 1'b1; ia.sel = 3'd5;
    tick();
    ia.load = 1'b0;
    check("pre_rst_y", ia.y, 8'h20);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_y", ia.y, 8'h00);
    check("async_rst_code", ia.code, 0);
    check("async_rst_b_y", ib.y, 8'hFF);
    #2 rst_n = 1'b1;
    tick();

    // uninterrupted sweep
    sweep_a(1000, 0, 40, done_at, errs);
    check("sweep_done_edge", done_at, 32);
    check("sweep_walk_errs", errs, 0);
    check("sweep_done_busy", ia.busy, 0);
    check("sweep_done_code", ia.code, 7);
    ia.start = 1'b1;
    tick();
    check("done_start_ignored_busy", ia.busy, 0);
    check("done_single_pulse", ia.done, 0);
    check("done_code_hold", ia.code, 7);
    tick();
    ia.start = 1'b0;
    check("idle_restart_busy", ia.busy, 1);
    check("idle_restart_code", ia.code, 0);
    wait_done_a("restart_done_seen", 40);
    tick();

    // pause for 5 clocks while code=3
    sweep_a(14, 5, 50, done_at, errs);
    check("pause_done_edge", done_at, 37);
    check("pause_walk_errs", errs, 0);
    tick();

    // start beats load; load ignored while sweeping
    ia.start = 1'b1; ia.load = 1'b1; ia.sel = 3'd5;
    tick();
    ia.start = 1'b0;
    check("prio_code", ia.code, 0);
    check("prio_busy", ia.busy, 1);
    ia.sel = 3'd6;
    tick();
    ia.load = 1'b0;
    check("sweep_load_ignored", ia.code, 0);
    wait_done_a("prio_done_seen", 40);
    tick();

    // active-low, single-cycle hold instance
    ib.en = 1'b1; ib.load = 1'b1; ib.sel = 3'd2;
    tick();
    ib.load = 1'b0;
    check("b_load_y", ib.y, 8'hFB);
    ib.en = 1'b0;
    tick();
    check("b_en_off_y", ib.y, 8'hFF);
    ib.en = 1'b1; ib.start = 1'b1;
    tick();
    ib.start = 1'b0;
    check("b_start_y", ib.y, 8'hFE);
    errs = 0;
    done_at = -1;
    for (int n = 1; n <= 12 && done_at < 0; n++) begin
      int k;
      logic [7:0] ey;
      tick();
      k  = (n > 7) ? 7 : n;
      ey = 8'h01 << k;
      if (ib.y !== ~ey) errs++;
      if (ib.done) done_at = n;
    end
    check("b_sweep_done_edge", done_at, 8);
    check("b_sweep_walk_errs", errs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
